// File: rtl/serial_pkg.sv
// Constants shared by both ends of the single-wire serial link:
// FSM state encodings, line levels and a width helper.
package serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Width of an index covering 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_tx_frame_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle
// of each bit period. Held at zero while clear is asserted.
module baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic resetp,
    input  logic clear,
    output logic tick
);
    import serial_pkg::*;

    localparam int                CNT_W    = idx_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/serial_tx_frame.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, stop bit,
// each held CLKS_PER_BIT clocks. All outputs come straight from flops.
module serial_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clock,
    input  logic              resetp,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    import serial_pkg::*;

    localparam int               IDX_W    = idx_width(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              tx_q,    tx_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic bit_tick;
    logic baud_clear;

    // The timer idles at zero so it starts a fresh bit period on acceptance.
    assign baud_clear = (state_q == ST_IDLE);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock (clock),
        .resetp(resetp),
        .clear (baud_clear),
        .tick  (bit_tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d   = LINE_IDLE;
                busy_d = 1'b0;
                if (start) begin
                    shift_d = data_in;
                    idx_d   = '0;
                    state_d = ST_START;
                    tx_d    = LINE_START;
                    busy_d  = 1'b1;
                end
            end

            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                        tx_d    = LINE_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        // Next bit to send is the new LSB after the shift.
                        tx_d  = shift_d[0];
                    end
                end
            end

            ST_STOP: begin
                if (bit_tick) begin
                    state_d = ST_IDLE;
                    tx_d    = LINE_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                shift_d = '0;
                idx_d   = '0;
                tx_d    = LINE_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Directed bench for serial_tx_frame: one 8-bit/4-clock instance for the main
// scenarios and one 1-bit/2-clock instance for the minimum-parameter case.
module tb_serial_tx_frame;

    logic       clock = 1'b0;
    logic       resetp = 1'b0;

    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx, busy, done;

    logic       start_e = 1'b0;
    logic [0:0] data_e = 1'b0;
    logic       tx_e, busy_e, done_e;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clock  (clock),
        .resetp (resetp),
        .start  (start),
        .data_in(data_in),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    serial_tx_frame #(.DATA_W(1), .CLKS_PER_BIT(2)) dut_e (
        .clock  (clock),
        .resetp (resetp),
        .start  (start_e),
        .data_in(data_e),
        .tx     (tx_e),
        .busy   (busy_e),
        .done   (done_e)
    );

    task automatic test_reset();
        #1 resetp = 1'b1;
        #1;
        checks++;
        if ({tx, busy, done, tx_e, busy_e, done_e} !== 6'b100_100) begin
            errors++;
            $display("FAIL reset_initial: got tx/busy/done=%b%b%b edge=%b%b%b, want 100 100",
                     tx, busy, done, tx_e, busy_e, done_e);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({tx, busy, done, tx_e, busy_e, done_e} !== 6'b100_100) begin
                errors++;
                $display("FAIL reset_held cycle %0d: got %b%b%b %b%b%b, want 100 100",
                         i, tx, busy, done, tx_e, busy_e, done_e);
            end
        end
        resetp = 1'b0;
        repeat (2) @(negedge clock);
        // Mid-idle reset: outputs must stay at the idle level immediately and while held.
        resetp = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({tx, busy, done} !== 3'b100) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got tx/busy/done=%b%b%b, want 100",
                         i, tx, busy, done);
            end
            @(negedge clock);
        end
        resetp = 1'b0;
        @(negedge clock);
        $display("reset: idle-line state checked");
    endtask

    task automatic test_single_frame();
        logic [9:0] lv;
        lv = 10'b1101001010;  // slot 0 = start, slots 1..8 = A5 LSB first, slot 9 = stop
        start = 1'b1; data_in = 8'hA5;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({tx, busy, done} !== {lv[i/4], 2'b10}) begin
                errors++;
                $display("FAIL single_a5 cycle %0d: got tx/busy/done=%b%b%b, want %b10",
                         i, tx, busy, done, lv[i/4]);
            end
            @(negedge clock);
        end
        checks++;
        if ({tx, busy, done} !== 3'b101) begin
            errors++;
            $display("FAIL single_a5_done: got tx/busy/done=%b%b%b, want 101", tx, busy, done);
        end
        @(negedge clock);
        checks++;
        if ({tx, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL single_a5_after: got tx/busy/done=%b%b%b, want 100", tx, busy, done);
        end
        $display("single frame: data=A5 sent");
    endtask

    task automatic test_ignored_start();
        logic [9:0] lv;
        lv = 10'b1101001010;
        start = 1'b1; data_in = 8'hA5;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({tx, busy, done} !== {lv[i/4], 2'b10}) begin
                errors++;
                $display("FAIL ignored_start cycle %0d: got tx/busy/done=%b%b%b, want %b10",
                         i, tx, busy, done, lv[i/4]);
            end
            if (i == 10) begin
                start = 1'b1; data_in = 8'hFF;
            end
            if (i == 11) start = 1'b0;
            @(negedge clock);
        end
        checks++;
        if ({tx, busy, done} !== 3'b101) begin
            errors++;
            $display("FAIL ignored_start_done: got tx/busy/done=%b%b%b, want 101", tx, busy, done);
        end
        @(negedge clock);
        checks++;
        if ({tx, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL ignored_start_after: got tx/busy/done=%b%b%b, want 100", tx, busy, done);
        end
        $display("ignored start: A5 frame with mid-frame FF strobe");
    endtask

    task automatic test_back_to_back();
        logic [9:0] lv0, lv1;
        logic [2:0] want;
        lv0 = 10'b1000000000;
        lv1 = 10'b1111111110;
        start = 1'b1; data_in = 8'h00;
        @(negedge clock);
        for (int i = 0; i < 82; i++) begin
            if (i < 40)       want = {lv0[i/4], 2'b10};
            else if (i == 40) want = 3'b101;
            else if (i < 81)  want = {lv1[(i-41)/4], 2'b10};
            else              want = 3'b101;
            checks++;
            if ({tx, busy, done} !== want) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got tx/busy/done=%b%b%b, want %b",
                         i, tx, busy, done, want);
            end
            if (i == 1)  data_in = 8'hFF;
            if (i == 41) start = 1'b0;
            @(negedge clock);
        end
        checks++;
        if ({tx, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL back_to_back_after: got tx/busy/done=%b%b%b, want 100", tx, busy, done);
        end
        $display("back to back: frames 00 then FF");
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] lv_a, lv_b;
        lv_a = 10'b1001111000;  // 3C
        lv_b = 10'b1100000010;  // 81
        start = 1'b1; data_in = 8'h3C;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if ({tx, busy, done} !== {lv_a[i/4], 2'b10}) begin
                errors++;
                $display("FAIL mid_reset_pre cycle %0d: got tx/busy/done=%b%b%b, want %b10",
                         i, tx, busy, done, lv_a[i/4]);
            end
            @(negedge clock);
        end
        resetp = 1'b1;
        #1;
        checks++;
        if ({tx, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_async: got tx/busy/done=%b%b%b, want 100", tx, busy, done);
        end
        repeat (2) @(negedge clock);
        resetp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({tx, busy, done} !== 3'b100) begin
                errors++;
                $display("FAIL mid_reset_idle cycle %0d: got tx/busy/done=%b%b%b, want 100",
                         i, tx, busy, done);
            end
        end
        start = 1'b1; data_in = 8'h81;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 41; i++) begin
            checks++;
            if (i < 40 && {tx, busy, done} !== {lv_b[i/4], 2'b10}) begin
                errors++;
                $display("FAIL mid_reset_81 cycle %0d: got tx/busy/done=%b%b%b, want %b10",
                         i, tx, busy, done, lv_b[i/4]);
            end else if (i == 40 && {tx, busy, done} !== 3'b101) begin
                errors++;
                $display("FAIL mid_reset_81_done: got tx/busy/done=%b%b%b, want 101",
                         tx, busy, done);
            end
            @(negedge clock);
        end
        $display("reset mid frame: 3C abandoned, 81 sent");
    endtask

    task automatic test_edge_params();
        logic [2:0] lv;
        lv = 3'b110;  // start, data bit 1, stop
        start_e = 1'b1; data_e = 1'b1;
        @(negedge clock);
        start_e = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] want;
            if (i < 6)       want = {lv[i/2], 2'b10};
            else if (i == 6) want = 3'b101;
            else             want = 3'b100;
            checks++;
            if ({tx_e, busy_e, done_e} !== want) begin
                errors++;
                $display("FAIL edge_params cycle %0d: got tx/busy/done=%b%b%b, want %b",
                         i, tx_e, busy_e, done_e, want);
            end
            @(negedge clock);
        end
        $display("edge params: DATA_W=1 CLKS_PER_BIT=2 data=1 sent");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        repeat (3) @(negedge clock);
        test_ignored_start();
        repeat (2) @(negedge clock);
        test_back_to_back();
        repeat (2) @(negedge clock);
        test_reset_mid_frame();
        repeat (2) @(negedge clock);
        test_edge_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_frame.md
# serial_tx_frame

Parallel-to-serial frame transmitter: accepts a DATA_W-bit word on a single-cycle start strobe and shifts it out on one line as start bit, data bits (LSB first), and stop bit, each held for CLKS_PER_BIT clocks. It is the sending end of the team's single-wire serial link. Its output feeds the flip-flop capture/receiver side, and on the board its inputs come from the switches. All outputs are registered, and reset is asynchronous to a safe idle-line state.

## Interface
- DATA_W, 8: payload width in bits; must be ≥ 1.
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥ 2.
- clock  in  1  system clock; all state changes on rising edge.
- resetp  in  1  reset, asynchronous, active-high.
- start  in  1  request to transmit data_in; sampled each rising edge.
- data_in  in  DATA_W  word to send; sampled only on an accepted start.
- tx  out  1  serial line; idle/stop = 1, start = 0.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - start=1 is accepted: data_in is latched into the shift register and the baud counter clears.
  - Next state START; tx←0, busy←1.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - tx = shift_reg[0] for CLKS_PER_BIT cycles.
  - Then shift right and increment the bit index.
  - After bit DATA_W−1, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE with busy←0 and done←1 for exactly one cycle.
- start while busy=1 is ignored: no latch, no queueing, and data_in changes have no effect mid-frame.
- start in the cycle done=1 (state IDLE) is accepted, so back-to-back frames are allowed.
- Baud counter:
  - Counts 0..CLKS_PER_BIT−1 and wraps to 0 on each bit boundary.
  - Width $clog2(CLKS_PER_BIT).
- Bit index: width $clog2(DATA_W) (minimum 1 bit), range 0..DATA_W−1, no wrap past DATA_W−1.
- Reset (any time, including mid-frame):
  - Outputs immediately go to tx=1, busy=0, done=0.
  - State goes to IDLE; counters and shift register clear to 0.
  - The partial frame is abandoned.
- Illegal state encodings recover to IDLE on the next edge.

## Timing
- Reset values: tx=1, busy=0, done=0.
- Accepting edge E (start=1, IDLE): tx=0 and busy=1 are visible from E onward.
- Data bit k drives tx during cycles E+(k+1)·CLKS_PER_BIT .. E+(k+2)·CLKS_PER_BIT−1.
- Stop bit occupies the final CLKS_PER_BIT cycles of the frame.
- Frame length is (DATA_W+2)·CLKS_PER_BIT cycles. At edge E+(DATA_W+2)·CLKS_PER_BIT: busy←0, done←1, tx stays 1.
- done falls at the following edge unless… it always falls; done is never high for 2 consecutive cycles.
- Back-to-back: minimum start-to-start spacing is (DATA_W+2)·CLKS_PER_BIT+1 cycles. The line stays high for at least CLKS_PER_BIT+1 cycles between frames.
- Combinational path from inputs to outputs: none.

## Structure
- Shared package/include serial_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3.
  - Line levels LINE_IDLE=1'b1, LINE_START=1'b0.
  - Reused by the receiver.
- Sub-module baud_counter (params CLKS_PER_BIT; ports clock, resetp, clear, tick):
  - tick pulses on the last cycle of each bit period.
  - Shared with the receiver.
- Top-level board wrapper connections:
  - SW[7:0] → data_in
  - SW[8] → start, via a one-pulse edge detector
  - KEY/SW[9] → resetp
  - tx → LEDR[0]
  - busy → LEDR[1]

## Test plan
- Reset: assert resetp for 3 cycles mid-idle → tx=1, busy=0, done=0 immediately and while held.
- Single frame, DATA_W=8, CLKS_PER_BIT=4, data_in=8'hA5:
  - tx sequence over 40 cycles, 4 cycles per level: 0, 1,0,1,0,0,1,0,1, 1.
  - busy high for exactly 40 cycles; done pulses once, 1 cycle, at cycle 40.
- Ignored start: during the 8'hA5 frame, pulse start with data_in=8'hFF at cycle 10 → waveform identical to the undisturbed 8'hA5 frame.
- Back-to-back: start held high continuously with 8'h00 then 8'hFF → second frame's start bit begins the cycle after done. Bits are all-0 then all-1.
- Reset mid-frame: assert resetp at cycle 17 of an 8'h3C frame → tx=1, busy=0 asynchronously.
  - After release, start with 8'h81 yields a clean full 8'h81 frame.
- Edge parameters: DATA_W=1, CLKS_PER_BIT=2, data_in=1 → tx = 0,0,1,1,1,1 and done at cycle 6.
